// File: rtl/multi_alarm_clock.sv
// 24h BCD clock with N programmable alarm slots, a shared ringing FSM and auto-timeout.
// Optional snooze support is built when the SNOOZE_EN macro is defined.
module multi_alarm_clock #(
    parameter int unsigned CLK_DIV      = 10,
    parameter int unsigned N_ALARMS     = 4,
    parameter int unsigned SNOOZE_MIN   = 5,
    parameter int unsigned RING_TIMEOUT = 60,
    localparam int unsigned SelW        = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            ld_time_i,
    input  logic            ld_alarm_i,
    input  logic [SelW-1:0] alarm_sel_i,
    input  logic            alarm_arm_i,
    input  logic [1:0]      h1_i,
    input  logic [3:0]      h0_i,
    input  logic [2:0]      m1_i,
    input  logic [3:0]      m0_i,
    input  logic            stop_alarm_i,
    input  logic            snooze_i,
    output logic [1:0]      hh1_o,
    output logic [3:0]      hh0_o,
    output logic [2:0]      mm1_o,
    output logic [3:0]      mm0_o,
    output logic [2:0]      ss1_o,
    output logic [3:0]      ss0_o,
    output logic            tick_1s_o,
    output logic            alarm_o,
    output logic [SelW-1:0] alarm_id_o,
    output logic            load_err_o
);

    localparam int unsigned PreW = $clog2(CLK_DIV);
    localparam logic [PreW-1:0] PreMax = PreW'(CLK_DIV - 1);
    localparam logic [7:0] RingInit = 8'(RING_TIMEOUT);

`ifdef SNOOZE_EN
    localparam logic [11:0] SnzInit = 12'(SNOOZE_MIN * 60);
    typedef enum logic [1:0] {StIdle, StRinging, StSnoozed} state_e;
    logic [11:0] snz_cnt_q;
`else
    typedef enum logic [1:0] {StIdle, StRinging} state_e;
    logic unused_snooze;
    assign unused_snooze = snooze_i;
`endif

    logic [PreW-1:0] pre_q, pre_d;
    logic [1:0] hh1_q, hh1_d;
    logic [3:0] hh0_q, hh0_d;
    logic [2:0] mm1_q, mm1_d;
    logic [3:0] mm0_q, mm0_d;
    logic [2:0] ss1_q, ss1_d;
    logic [3:0] ss0_q, ss0_d;
    logic [12:0] slot_q [N_ALARMS];
    logic [N_ALARMS-1:0] arm_q;
    logic load_err_q;

    state_e state_q;
    logic alarm_q;
    logic [SelW-1:0] alarm_id_q;
    logic [7:0] ring_cnt_q;

    logic in_valid, time_ld, alarm_ld, tick, min_roll, match;
    logic [SelW-1:0] match_id;

    assign in_valid = !((h1_i == 2'd3) || (h1_i == 2'd2 && h0_i > 4'd3) || (h0_i > 4'd9) ||
                        (m1_i > 3'd5) || (m0_i > 4'd9));
    assign time_ld  = ld_time_i && in_valid;
    assign alarm_ld = ld_alarm_i && in_valid;
    // A time load restarts the second, so it suppresses any tick due this cycle.
    assign tick     = (pre_q == PreMax) && !time_ld;
    assign min_roll = tick && (ss1_q == 3'd5) && (ss0_q == 4'd9);

    always_comb begin
        pre_d = (pre_q == PreMax) ? '0 : pre_q + 1'b1;
        hh1_d = hh1_q;
        hh0_d = hh0_q;
        mm1_d = mm1_q;
        mm0_d = mm0_q;
        ss1_d = ss1_q;
        ss0_d = ss0_q;
        if (time_ld) begin
            pre_d = '0;
            hh1_d = h1_i;
            hh0_d = h0_i;
            mm1_d = m1_i;
            mm0_d = m0_i;
            ss1_d = '0;
            ss0_d = '0;
        end else if (tick) begin
            if (ss0_q != 4'd9) ss0_d = ss0_q + 4'd1;
            else begin
                ss0_d = '0;
                if (ss1_q != 3'd5) ss1_d = ss1_q + 3'd1;
                else begin
                    ss1_d = '0;
                    if (mm0_q != 4'd9) mm0_d = mm0_q + 4'd1;
                    else begin
                        mm0_d = '0;
                        if (mm1_q != 3'd5) mm1_d = mm1_q + 3'd1;
                        else begin
                            mm1_d = '0;
                            if (hh1_q == 2'd2 && hh0_q == 4'd3) begin
                                hh1_d = '0;
                                hh0_d = '0;
                            end else if (hh0_q == 4'd9) begin
                                hh0_d = '0;
                                hh1_d = hh1_q + 2'd1;
                            end else begin
                                hh0_d = hh0_q + 4'd1;
                            end
                        end
                    end
                end
            end
        end
    end

    // Descending scan so the lowest-index matching slot is the one left standing.
    always_comb begin
        match    = 1'b0;
        match_id = '0;
        for (int i = int'(N_ALARMS) - 1; i >= 0; i--) begin
            if (arm_q[i] && slot_q[i] == {hh1_d, hh0_d, mm1_d, mm0_d}) begin
                match    = 1'b1;
                match_id = SelW'(i);
            end
        end
        if (!min_roll) match = 1'b0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pre_q      <= '0;
            hh1_q      <= '0;
            hh0_q      <= '0;
            mm1_q      <= '0;
            mm0_q      <= '0;
            ss1_q      <= '0;
            ss0_q      <= '0;
            arm_q      <= '0;
            load_err_q <= 1'b0;
            for (int i = 0; i < int'(N_ALARMS); i++) slot_q[i] <= '0;
        end else begin
            pre_q      <= pre_d;
            hh1_q      <= hh1_d;
            hh0_q      <= hh0_d;
            mm1_q      <= mm1_d;
            mm0_q      <= mm0_d;
            ss1_q      <= ss1_d;
            ss0_q      <= ss0_d;
            load_err_q <= (ld_time_i || ld_alarm_i) && !in_valid;
            for (int i = 0; i < int'(N_ALARMS); i++) begin
                if (alarm_ld && alarm_sel_i == SelW'(i)) begin
                    slot_q[i] <= {h1_i, h0_i, m1_i, m0_i};
                    arm_q[i]  <= alarm_arm_i;
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            alarm_q    <= 1'b0;
            alarm_id_q <= '0;
            ring_cnt_q <= '0;
`ifdef SNOOZE_EN
            snz_cnt_q  <= '0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (match) begin
                        state_q    <= StRinging;
                        alarm_q    <= 1'b1;
                        alarm_id_q <= match_id;
                        ring_cnt_q <= RingInit;
                    end
                end
                StRinging: begin
                    if (stop_alarm_i) begin
                        state_q <= StIdle;
                        alarm_q <= 1'b0;
`ifdef SNOOZE_EN
                    end else if (snooze_i) begin
                        state_q   <= StSnoozed;
                        alarm_q   <= 1'b0;
                        snz_cnt_q <= SnzInit;
`endif
                    end else if (tick) begin
                        if (ring_cnt_q <= 8'd1) begin
                            state_q    <= StIdle;
                            alarm_q    <= 1'b0;
                            ring_cnt_q <= '0;
                        end else begin
                            ring_cnt_q <= ring_cnt_q - 8'd1;
                        end
                    end
                end
`ifdef SNOOZE_EN
                StSnoozed: begin
                    if (stop_alarm_i) begin
                        state_q <= StIdle;
                    end else if (tick) begin
                        if (snz_cnt_q <= 12'd1) begin
                            state_q    <= StRinging;
                            alarm_q    <= 1'b1;
                            ring_cnt_q <= RingInit;
                            snz_cnt_q  <= '0;
                        end else begin
                            snz_cnt_q <= snz_cnt_q - 12'd1;
                        end
                    end
                end
`endif
                default: begin
                    state_q <= StIdle;
                    alarm_q <= 1'b0;
                end
            endcase
        end
    end

    assign hh1_o      = hh1_q;
    assign hh0_o      = hh0_q;
    assign mm1_o      = mm1_q;
    assign mm0_o      = mm0_q;
    assign ss1_o      = ss1_q;
    assign ss0_o      = ss0_q;
    assign tick_1s_o  = tick;
    assign alarm_o    = alarm_q;
    assign alarm_id_o = alarm_id_q;
    assign load_err_o = load_err_q;

endmodule
